mux_pipe_n: RTL and testbench

Parametrised registered N:1 selector for the pipelined datapath, successor to the fixed-width two-input combinational muxes. It selects one of N WIDTH-bit channels, captures the result into a two-entry skid buffer, and presents it downstream with a valid/ready handshake. Stall (ready low) and flush are handled locally, so stage-boundary selects (register index, forwarding operands) can sit directly on a pipeline register.

---
 rtl/mux_pkg.sv | 4 +
 rtl/mux_n_1.sv | 22 ++
 rtl/mux_pipe_n.sv | 89 ++++++++
 tb/tb_mux_pipe_n.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared state type for the pipelined N:1 selector.
package mux_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t;
endpackage

// File: rtl/mux_n_1.sv
// mux_n_1: combinational WIDTH-bit N:1 select with an out-of-range flag.
module mux_n_1 #(
  parameter int WIDTH = 5,
  parameter int N = 2,
  localparam int SELW = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err
);
  logic [N-1:0][WIDTH-1:0] w_masked;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign w_masked[i] = (32'(sel) == i) ? in_data[i*WIDTH +: WIDTH] : '0;
  end
  // An out-of-range select matches no channel, so the OR-reduction yields zero.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++) out_data = out_data | w_masked[j];
  end
  assign out_err = 32'(sel) >= N;
endmodule

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: registered N:1 selector feeding a two-entry skid buffer
// with a valid/ready handshake and synchronous flush.
module mux_pipe_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int N = 2,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  sel;
    logic             err;
  } beat_t;
  pipe_state_t r_state, w_next;
  beat_t r_main, r_skid, w_beat;
  logic [WIDTH-1:0] w_data;
  logic w_err, w_acc, w_con, w_ld_main, w_ld_skid, w_from_skid;
  mux_n_1 #(.WIDTH(WIDTH), .N(N)) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (w_data),
    .out_err  (w_err)
  );
  assign w_beat = '{data: w_data, sel: sel, err: w_err};
  assign w_acc = in_valid && in_ready;
  assign w_con = out_valid && out_ready;
  always_comb begin
    w_next = r_state;
    w_ld_main = 1'b0;
    w_ld_skid = 1'b0;
    w_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        w_ld_main = w_acc;
        w_next = w_acc ? ONE : EMPTY;
      end
      ONE: begin
        w_ld_main = w_acc && w_con;
        w_ld_skid = w_acc && !w_con;
        w_next = w_ld_skid ? TWO : (w_con && !w_acc) ? EMPTY : ONE;
      end
      TWO: begin
        w_from_skid = w_con;
        w_next = w_con ? ONE : TWO;
      end
      default: w_next = EMPTY;
    endcase
    // Flush drops any incoming beat; a concurrent consume has already completed downstream.
    if (flush) begin
      w_next = EMPTY;
      w_ld_main = 1'b0;
      w_ld_skid = 1'b0;
      w_from_skid = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main) r_main <= w_beat;
      else if (w_from_skid) r_main <= r_skid;
      if (w_ld_skid) r_skid <= w_beat;
    end
  end
  assign in_ready = r_state != TWO;
  assign out_valid = r_state != EMPTY;
  assign out_data = r_main.data;
  assign out_sel = r_main.sel;
  assign out_err = r_main.err;
endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: random and directed stimulus on N=4 and N=3 instances,
// checked every cycle against a queue-based model of the buffer.
module tb_mux_pipe_n;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic [19:0] d4 = '0;
  logic [14:0] d3;
  logic [1:0] s4 = '0, s3 = '0;
  logic rdy4, ov4, oe4, rdy3, ov3, oe3;
  logic [4:0] od4, od3;
  logic [1:0] os4, os3;
  int errs = 0, checks = 0;
  typedef struct {int data; int sel; bit err;} bt;
  bt q4[$], q3[$];
  bit a4, c4, a3, c3;
  logic [4:0] held;
  assign d3 = d4[14:0];
  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(5), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(s4), .in_valid(in_valid),
    .in_ready(rdy4), .flush(flush), .out_data(od4), .out_sel(os4),
    .out_err(oe4), .out_valid(ov4), .out_ready(out_ready)
  );
  mux_pipe_n #(.WIDTH(5), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .sel(s3), .in_valid(in_valid),
    .in_ready(rdy3), .flush(flush), .out_data(od3), .out_sel(os3),
    .out_err(oe3), .out_valid(ov3), .out_ready(out_ready)
  );

  function automatic bt mk(int n, logic [19:0] d, logic [1:0] s);
    bt b;
    b.sel = int'(s);
    b.err = b.sel >= n;
    b.data = b.err ? 0 : int'((d >> (b.sel * 5)) & 20'h1F);
    return b;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an in-order queue holding at most two beats.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q4.delete();
      q3.delete();
    end else begin
      a4 = in_valid && q4.size() < 2;
      c4 = out_ready && q4.size() > 0;
      a3 = in_valid && q3.size() < 2;
      c3 = out_ready && q3.size() > 0;
      if (flush) begin
        q4.delete();
        q3.delete();
      end else begin
        if (c4) void'(q4.pop_front());
        if (a4) q4.push_back(mk(4, d4, s4));
        if (c3) void'(q3.pop_front());
        if (a3) q3.push_back(mk(3, {5'd0, d3}, s3));
      end
    end
  end

  always @(negedge clk) begin
    chk("n4_in_ready", 32'(rdy4), 32'(q4.size() < 2));
    chk("n4_out_valid", 32'(ov4), 32'(q4.size() > 0));
    if (q4.size() > 0) begin
      chk("n4_out_data", 32'(od4), q4[0].data);
      chk("n4_out_sel", 32'(os4), q4[0].sel);
      chk("n4_out_err", 32'(oe4), 32'(q4[0].err));
    end
    chk("n3_in_ready", 32'(rdy3), 32'(q3.size() < 2));
    chk("n3_out_valid", 32'(ov3), 32'(q3.size() > 0));
    if (q3.size() > 0) begin
      chk("n3_out_data", 32'(od3), q3[0].data);
      chk("n3_out_sel", 32'(os3), q3[0].sel);
      chk("n3_out_err", 32'(oe3), 32'(q3[0].err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_valid"}, 32'(ov4), 0);
    chk({nm, "_ready"}, 32'(rdy4), 1);
    chk({nm, "_data"}, 32'(od4), 0);
    chk({nm, "_sel"}, 32'(os4), 0);
    chk({nm, "_err"}, 32'(oe4), 0);
  endtask

  initial begin
    #2 chk_reset("reset_init");
    step();
    step();
    rst_n = 1;
    // Streaming: one beat per cycle, one cycle behind each accept.
    d4 = {5'h1F, 5'h15, 5'h0A, 5'h01};
    out_ready = 1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        in_valid = 1;
        s4 = 2'(i);
      end else in_valid = 0;
      step();
      if (i < 4) begin
        chk("stream_valid", 32'(ov4), 1);
        chk("stream_data", 32'(od4), 32'(d4[i*5 +: 5]));
      end
    end
    chk("stream_drained", 32'(ov4), 0);
    // Backpressure: three stalled cycles with in_valid high.
    out_ready = 0;
    in_valid = 1;
    s4 = 1;
    step();
    chk("bp_ready1", 32'(rdy4), 1);
    s4 = 2;
    step();
    chk("bp_ready2", 32'(rdy4), 0);
    chk("bp_head2", 32'(od4), 32'h0A);
    s4 = 3;
    step();
    chk("bp_ready3", 32'(rdy4), 0);
    chk("bp_head3", 32'(od4), 32'h0A);
    out_ready = 1;
    in_valid = 0;
    step();
    chk("bp_drain1", 32'(od4), 32'h15);
    chk("bp_drain1_valid", 32'(ov4), 1);
    step();
    chk("bp_drain_empty", 32'(ov4), 0);
    // Flush collision from TWO.
    out_ready = 0;
    in_valid = 1;
    s4 = 0;
    step();
    step();
    chk("fl_two", 32'(rdy4), 0);
    flush = 1;
    s4 = 3;
    step();
    chk("fl_valid", 32'(ov4), 0);
    chk("fl_ready", 32'(rdy4), 1);
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    step();
    chk("fl_no_ghost", 32'(ov4), 0);
    // Out-of-range on N=3 plus hold stability while stalled.
    d4 = 20'hFFFFF;
    s4 = 2;
    s3 = 3;
    in_valid = 1;
    out_ready = 0;
    step();
    chk("oor_data", 32'(od3), 0);
    chk("oor_err", 32'(oe3), 1);
    chk("oor_sel", 32'(os3), 3);
    held = od4;
    chk("hold_first", 32'(held), 32'h1F);
    for (int i = 0; i < 5; i++) begin
      d4 = 20'($urandom);
      s4 = 2'($urandom);
      s3 = 2'($urandom);
      in_valid = 1'($urandom);
      step();
      chk("hold_data", 32'(od4), 32'(held));
      chk("hold_sel", 32'(os4), 2);
      chk("hold_err3", 32'(oe3), 1);
    end
    // Asynchronous reset while holding two beats.
    in_valid = 1;
    step();
    step();
    chk("rst_pre_two", 32'(rdy4), 0);
    #2 rst_n = 0;
    #1 chk_reset("reset_mid");
    step();
    rst_n = 1;
    in_valid = 0;
    step();
    chk("rst_after_empty", 32'(ov4), 0);
    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      d4 = 20'($urandom);
      s4 = 2'($urandom);
      s3 = 2'($urandom);
      step();
    end
    in_valid = 0;
    flush = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
